rst_seq: RTL and testbench
==========================

# rst_seq

Reset sequencer that drives the per-domain reset inputs of the design. It takes the chip-level reset plus software and watchdog reset requests, stretches every reset event to a guaranteed minimum width, and then releases NUM_RST downstream reset outputs one at a time with a fixed gap. It records the cause of the most recent resets in a sticky register that firmware can read and clear. Each rst_out_n bit is meant to feed a per-domain rst_sync instance. The assertion path of each rst_out_n bit is registered; the rst_n path is asynchronous.

## Interface
- NUM_RST, 3, number of sequenced reset outputs (1..8)
- STRETCH, 16, minimum reset assertion length in clk cycles (>= 2)
- GAP, 8, cycles between consecutive output releases (>= 1)
- CNT_W, 8, counter width; must hold max(STRETCH, GAP) - 1
- clk  input  1  sole clock
- rst_n  input  1  asynchronous, active-low chip reset
- sw_req  input  1  software reset request, synchronous to clk, level-sampled
- wdt_req  input  1  watchdog reset request, synchronous to clk, level-sampled
- hold  input  1  debug hold-in-reset, synchronous, level-sampled
- cause_clr  input  1  clears cause register, synchronous pulse
- rst_out_n  output  NUM_RST  active-low domain resets; bit 0 is released first
- busy  output  1  high while any rst_out_n bit is low
- cause  output  3  sticky cause flags: [0] power-on/rst_n, [1] sw, [2] wdt

## Operation
- The request term is req = sw_req | wdt_req | hold.
- FSM states:
  - ASSERT: all outputs low; counter cnt runs.
  - RELEASE: outputs are deasserted in index order.
  - RUN: all outputs high.
- rst_n low (asynchronous):
  - state = ASSERT, cnt = 0, idx = 0
  - rst_out_n = all 0, busy = 1, cause = 3'b001
- ASSERT:
  - req high: cnt <= 0.
  - req low and cnt == STRETCH-1: go to RELEASE, set rst_out_n[0] <= 1, cnt <= 0, idx <= 1.
  - Otherwise cnt <= cnt+1.
- RELEASE:
  - req high: go to ASSERT at once, rst_out_n <= 0, cnt <= 0, idx <= 0.
  - cnt == GAP-1: rst_out_n[idx] <= 1, idx <= idx+1, cnt <= 0.
  - When the bit just released is NUM_RST-1, go to RUN.
  - Otherwise cnt <= cnt+1.
- NUM_RST == 1: ASSERT goes straight to RUN, skipping RELEASE.
- RUN:
  - req high: go to ASSERT, rst_out_n <= 0, cnt <= 0.
  - Otherwise hold.
- busy = ~&rst_out_n, registered with the same timing as the outputs.
- cause:
  - A rising-edge sample of sw_req sets bit 1; wdt_req sets bit 2, in any state.
  - hold never sets a cause bit.
  - cause_clr clears all bits.
  - If a set and cause_clr occur in the same cycle, the set wins for that bit.
- Once released, rst_out_n bits never glitch low except on req or rst_n.

## Timing
- Edge numbering: edge 1 is the first rising clk edge with rst_n high, or the first edge after the last edge at which req was sampled high.
- rst_out_n[i] rises after edge STRETCH + i*GAP.
- busy falls on the same edge as rst_out_n[NUM_RST-1].
- req sampled high at edge e: all rst_out_n bits are low after edge e. Latency is 1 cycle; no combinational path from req.
- rst_n low: all rst_out_n bits are low immediately, with no clock needed.
- A req held for k cycles extends assertion. Release is measured from the last high sample.
- A req during RELEASE restarts the full sequence. Bits that were already released are reasserted on the same edge.
- A simultaneous sw_req and wdt_req sets both cause bits.

## Test plan
- Power-on, defaults: deassert rst_n at t0, no req.
  - rst_out_n[0] rises after edge 16, [1] after edge 24, [2] after edge 32.
  - busy falls after edge 32.
  - cause = 3'b001.
- SW reset in RUN: 1-cycle sw_req at edge e.
  - rst_out_n = 0 after edge e.
  - Releases after e+16, e+24, e+32.
  - cause = 3'b011.
- WDT request mid-RELEASE: wdt_req at the edge after rst_out_n[0] rose.
  - All bits low after that edge; sequence restarts from STRETCH.
  - cause[2] = 1.
- Hold: hold high for 40 cycles from RUN.
  - Outputs stay low throughout.
  - rst_out_n[0] rises 16 edges after the last high sample.
  - cause unchanged.
- Cause clear race: cause_clr and sw_req together at edge e.
  - cause = 3'b010 after edge e.
  - A following cause_clr alone gives 3'b000.
- Async reset mid-sequence: rst_n pulsed low between edges during RELEASE.
  - All outputs low before the next edge.
  - cause = 3'b001.
  - Power-on timing then repeats exactly.

Source files
------------

// File: rtl/rst_seq.sv
// rst_seq: reset sequencer. Stretches chip, software and watchdog reset
// events to a minimum width, then releases NUM_RST domain resets in index
// order with a fixed gap. Keeps a sticky, firmware-clearable reset cause.
module rst_seq #(
    parameter int unsigned NUM_RST = 3,
    parameter int unsigned STRETCH = 16,
    parameter int unsigned GAP     = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sw_req,
    input  logic               wdt_req,
    input  logic               hold,
    input  logic               cause_clr,
    output logic [NUM_RST-1:0] rst_out_n,
    output logic               busy,
    output logic [2:0]         cause
);

    localparam int unsigned IDX_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

    localparam logic [CNT_W-1:0] STRETCH_M1 = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0] GAP_M1     = CNT_W'(GAP - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_RST - 1);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_RST-1:0] rst_out_q, rst_out_d;
    logic               busy_q, busy_d;
    logic [2:0]         cause_q, cause_d;
    logic               req;

    assign req = sw_req | wdt_req | hold;

    // State, counters and registered reset outputs; rst_n forces all low at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ASSERT;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '0;
            busy_q    <= 1'b1;
            cause_q   <= 3'b001;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            busy_q    <= busy_d;
            cause_q   <= cause_d;
        end
    end

    // Next-state logic: stretch while asserted, then release one bit per gap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;

        unique case (state_q)
            ST_ASSERT: begin
                rst_out_d = '0;
                if (req) begin
                    cnt_d = '0;
                end else if (cnt_q == STRETCH_M1) begin
                    rst_out_d[0] = 1'b1;
                    cnt_d        = '0;
                    idx_d        = IDX_W'(1);
                    state_d      = (NUM_RST == 1) ? ST_RUN : ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (req) begin
                    state_d   = ST_ASSERT;
                    rst_out_d = '0;
                    cnt_d     = '0;
                    idx_d     = '0;
                end else if (cnt_q == GAP_M1) begin
                    rst_out_d[idx_q] = 1'b1;
                    idx_d            = idx_q + IDX_W'(1);
                    cnt_d            = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (req) begin
                    state_d   = ST_ASSERT;
                    rst_out_d = '0;
                    cnt_d     = '0;
                    idx_d     = '0;
                end
            end
            default: begin
                state_d   = ST_ASSERT;
                rst_out_d = '0;
                cnt_d     = '0;
                idx_d     = '0;
            end
        endcase
    end

    // busy tracks the next output value so it lands on the same edge as the last release.
    always_comb begin
        busy_d = ~&rst_out_d;
    end

    // Sticky cause: a request sample sets its bit and beats a same-cycle clear.
    always_comb begin
        cause_d = cause_clr ? 3'b000 : cause_q;
        cause_d = cause_d | {wdt_req, sw_req, 1'b0};
    end

    assign rst_out_n = rst_out_q;
    assign busy      = busy_q;
    assign cause     = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: the stimulus pushes each expected output
// change (cycle tag and {cause, busy, rst_out_n}) into a queue; the monitor
// pops an entry whenever the observed output vector changes.
module tb_rst_seq;

    logic       clk;
    logic       rst_n;
    logic       sw_req;
    logic       wdt_req;
    logic       hold;
    logic       cause_clr;
    logic [2:0] rst_out_n;
    logic       busy;
    logic [2:0] cause;

    typedef struct {
        int         cyc;
        logic [6:0] vec;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic       done = 1'b0;
    logic [6:0] prev_vec = 'x;

    rst_seq #(
        .NUM_RST(3),
        .STRETCH(16),
        .GAP(8),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_req(sw_req),
        .wdt_req(wdt_req),
        .hold(hold),
        .cause_clr(cause_clr),
        .rst_out_n(rst_out_n),
        .busy(busy),
        .cause(cause)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [6:0] v, input string nm);
        exp_t e;
        e.cyc  = c;
        e.vec  = v;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every change of {cause, busy, rst_out_n} with the queue head.
    always @(negedge clk) begin
        logic [6:0] cur;
        exp_t       e;
        cur = {cause, busy, rst_out_n};
        if (cur !== prev_vec) begin
            prev_vec = cur;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got vec=%b, none expected", cyc, cur);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.vec !== cur) begin
                    errors++;
                    $display("FAIL %s got cyc=%0d vec=%b, want cyc=%0d vec=%b",
                             e.name, cyc, cur, e.cyc, e.vec);
                end
            end
        end
        if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL queue_drain got %0d pending, want 0 (head %s)",
                         exp_q.size(), exp_q[0].name);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // Stimulus: vectors are {cause[2:0], busy, rst_out_n[2:0]}.
    initial begin
        int n;
        rst_n     = 1'b0;
        sw_req    = 1'b0;
        wdt_req   = 1'b0;
        hold      = 1'b0;
        cause_clr = 1'b0;

        // Power-on: reset state, then releases at edges 16, 24, 32.
        push(1, 7'b001_1_000, "por_reset_state");
        step();
        n = cyc;
        rst_n = 1'b1;
        push(n + 16, 7'b001_1_001, "por_rel0");
        push(n + 24, 7'b001_1_011, "por_rel1");
        push(n + 32, 7'b001_0_111, "por_rel2");
        repeat (40) step();

        // Software reset from RUN.
        n = cyc + 1;
        push(n,      7'b011_1_000, "sw_assert");
        push(n + 16, 7'b011_1_001, "sw_rel0");
        push(n + 24, 7'b011_1_011, "sw_rel1");
        push(n + 32, 7'b011_0_111, "sw_rel2");
        sw_req = 1'b1;
        step();
        sw_req = 1'b0;
        repeat (40) step();

        // One-cycle hold, then watchdog the edge after bit 0 rises.
        n = cyc + 1;
        push(n,      7'b011_1_000, "hold1_assert");
        push(n + 16, 7'b011_1_001, "hold1_rel0");
        push(n + 17, 7'b111_1_000, "wdt_midrelease");
        push(n + 33, 7'b111_1_001, "wdt_rel0");
        push(n + 41, 7'b111_1_011, "wdt_rel1");
        push(n + 49, 7'b111_0_111, "wdt_rel2");
        hold = 1'b1;
        step();
        hold = 1'b0;
        repeat (16) step();
        wdt_req = 1'b1;
        step();
        wdt_req = 1'b0;
        repeat (50) step();

        // Hold for 40 cycles: no change until 16 edges after the last high sample.
        n = cyc + 1;
        push(n,      7'b111_1_000, "hold40_assert");
        push(n + 55, 7'b111_1_001, "hold40_rel0");
        push(n + 63, 7'b111_1_011, "hold40_rel1");
        push(n + 71, 7'b111_0_111, "hold40_rel2");
        hold = 1'b1;
        repeat (40) step();
        hold = 1'b0;
        repeat (80) step();

        // Clear racing a software request, then a lone clear.
        n = cyc + 1;
        push(n,      7'b010_1_000, "clr_race");
        push(n + 1,  7'b000_1_000, "clr_alone");
        push(n + 16, 7'b000_1_001, "clr_rel0");
        push(n + 24, 7'b000_1_011, "clr_rel1");
        push(n + 32, 7'b000_0_111, "clr_rel2");
        sw_req    = 1'b1;
        cause_clr = 1'b1;
        step();
        sw_req = 1'b0;
        step();
        cause_clr = 1'b0;
        repeat (40) step();

        // Async reset pulse between edges during RELEASE, then power-on timing again.
        n = cyc + 1;
        push(n,      7'b010_1_000, "pre_async_assert");
        push(n + 16, 7'b010_1_001, "pre_async_rel0");
        push(n + 20, 7'b001_1_000, "async_reset");
        push(n + 36, 7'b001_1_001, "async_rel0");
        push(n + 44, 7'b001_1_011, "async_rel1");
        push(n + 52, 7'b001_0_111, "async_rel2");
        sw_req = 1'b1;
        step();
        sw_req = 1'b0;
        repeat (20) step();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
        repeat (4) step();
        done = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got no finish, want finish before 100000");
        $fatal(1);
    end

endmodule
